// File: rtl/taxi_pkg.sv
`default_nettype none
// taxi_pkg - shared types and constants for the taxi meter blocks.
// Rev 1.0
package taxi_pkg;

  localparam int TAXI_CLK_HZ          = 50_000_000;
  localparam int ODO_DEBOUNCE_DEFAULT = TAXI_CLK_HZ / 100;  // 10 ms
  localparam int ODO_STALL_DEFAULT    = TAXI_CLK_HZ * 2;    // 2 s

  localparam logic [1:0] ODO_PEND_MAX = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } odo_state_t;

endpackage
`default_nettype wire

// File: rtl/debounce.sv
`default_nettype none
// debounce - two-flop synchroniser followed by a stable-count debouncer.
// Rev 1.0
module debounce
  import taxi_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = ODO_DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic filt
);

  localparam int             DBW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

  logic           r_sync1;
  logic           r_sync2;
  logic           r_filt;
  logic [DBW-1:0] r_db_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_filt   <= 1'b0;
      r_db_cnt <= '0;
    end else begin
      r_sync1 <= din;
      r_sync2 <= r_sync1;
      // Accept the new level on the cycle the count would reach DEBOUNCE_CYCLES.
      if (r_sync2 != r_filt) begin
        if (r_db_cnt == DB_LAST) begin
          r_filt   <= r_sync2;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + 1'b1;
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  assign filt = r_filt;

endmodule
`default_nettype wire

// File: rtl/odometer_pulse_gen.sv
`default_nettype none
// odometer_pulse_gen - debounced wheel-edge divider producing queued 10 m pulses.
// Rev 1.0
module odometer_pulse_gen
  import taxi_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = ODO_DEBOUNCE_DEFAULT,
  parameter int EDGES_PER_10M   = 4,
  parameter int PULSE_HIGH      = 4,
  parameter int STALL_CYCLES    = ODO_STALL_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic hall_in,
  output logic ten_meter_pulse,
  output logic moving,
  output logic dropped
);

  localparam int SUBW = (EDGES_PER_10M > 1) ? $clog2(EDGES_PER_10M) : 1;
  localparam int PHW  = (PULSE_HIGH > 1)    ? $clog2(PULSE_HIGH)    : 1;
  localparam int STW  = (STALL_CYCLES > 1)  ? $clog2(STALL_CYCLES)  : 1;

  localparam logic [SUBW-1:0] SUB_LAST = SUBW'(EDGES_PER_10M - 1);
  localparam logic [PHW-1:0]  PH_LAST  = PHW'(PULSE_HIGH - 1);
  localparam logic [STW-1:0]  ST_LAST  = STW'(STALL_CYCLES - 1);

  logic            w_filt;
  logic            w_rise;
  logic            w_push;
  logic            w_pop;
  logic            r_filt_d;
  logic [SUBW-1:0] r_sub_cnt;
  logic [1:0]      r_pend;
  logic            r_dropped;
  odo_state_t      r_state;
  logic [PHW-1:0]  r_ph_cnt;
  logic            r_pulse;
  logic [STW-1:0]  r_stall_cnt;
  logic            r_moving;

  debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk (clk),
    .rst (rst),
    .din (hall_in),
    .filt(w_filt)
  );

  assign w_rise = w_filt & ~r_filt_d;
  assign w_push = en & w_rise & (r_sub_cnt == SUB_LAST);
  // A pulse may start from IDLE, or straight out of the last GAP cycle so queued pulses keep a 2*PULSE_HIGH pitch.
  assign w_pop  = en & (r_pend != 2'd0) &
                  ((r_state == IDLE) | ((r_state == GAP) & (r_ph_cnt == PH_LAST)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_filt_d  <= 1'b0;
      r_sub_cnt <= '0;
    end else begin
      r_filt_d <= w_filt;
      if (!en) begin
        r_sub_cnt <= '0;
      end else if (w_rise) begin
        r_sub_cnt <= (r_sub_cnt == SUB_LAST) ? '0 : r_sub_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend    <= 2'd0;
      r_dropped <= 1'b0;
    end else if (!en) begin
      r_pend    <= 2'd0;
      r_dropped <= 1'b0;
    end else if (w_push && !w_pop) begin
      if (r_pend == ODO_PEND_MAX) begin
        r_dropped <= 1'b1;
      end else begin
        r_pend <= r_pend + 2'd1;
      end
    end else if (!w_push && w_pop) begin
      r_pend <= r_pend - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_ph_cnt <= '0;
      r_pulse  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_state  <= HIGH;
            r_ph_cnt <= '0;
            r_pulse  <= 1'b1;
          end
        end
        HIGH: begin
          if (r_ph_cnt == PH_LAST) begin
            r_state  <= GAP;
            r_ph_cnt <= '0;
            r_pulse  <= 1'b0;
          end else begin
            r_ph_cnt <= r_ph_cnt + 1'b1;
          end
        end
        GAP: begin
          if (r_ph_cnt == PH_LAST) begin
            r_ph_cnt <= '0;
            if (w_pop) begin
              r_state <= HIGH;
              r_pulse <= 1'b1;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_ph_cnt <= r_ph_cnt + 1'b1;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_ph_cnt <= '0;
          r_pulse  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_moving    <= 1'b0;
    end else if (w_rise) begin
      r_stall_cnt <= '0;
      r_moving    <= 1'b1;
    end else if (r_stall_cnt == ST_LAST) begin
      r_moving <= 1'b0;
    end else begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign ten_meter_pulse = r_pulse;
  assign moving          = r_moving;
  assign dropped         = r_dropped;

endmodule
`default_nettype wire

// File: tb/tb_odometer_pulse_gen.sv
`default_nettype none
// tb_odometer_pulse_gen - directed checks; DUT A uses the small test parameters,
// DUT B uses a fast debouncer and long pulses so the pending queue can saturate.
module tb_odometer_pulse_gen;

  logic clk;
  logic rst;
  logic en;
  logic hall_a;
  logic hall_b;
  logic pulse_a, moving_a, dropped_a;
  logic pulse_b, moving_b, dropped_b;

  int checks;
  int failures;

  odometer_pulse_gen #(
    .DEBOUNCE_CYCLES(3),
    .EDGES_PER_10M  (2),
    .PULSE_HIGH     (2),
    .STALL_CYCLES   (50)
  ) u_dut_a (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .hall_in        (hall_a),
    .ten_meter_pulse(pulse_a),
    .moving         (moving_a),
    .dropped        (dropped_a)
  );

  odometer_pulse_gen #(
    .DEBOUNCE_CYCLES(1),
    .EDGES_PER_10M  (1),
    .PULSE_HIGH     (4),
    .STALL_CYCLES   (50)
  ) u_dut_b (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .hall_in        (hall_b),
    .ten_meter_pulse(pulse_b),
    .moving         (moving_b),
    .dropped        (dropped_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1;
    hall_a = 1'b1; hall_b = 1'b1;
    tick();
    hall_a = 1'b0; hall_b = 1'b0;
    tick();
    checks++; if (pulse_a !== 1'b0) begin failures++; $display("FAIL reset_pulse_a got %b expected 0", pulse_a); end
    checks++; if (moving_a !== 1'b0) begin failures++; $display("FAIL reset_moving_a got %b expected 0", moving_a); end
    checks++; if (dropped_a !== 1'b0) begin failures++; $display("FAIL reset_dropped_a got %b expected 0", dropped_a); end
    checks++; if (pulse_b !== 1'b0) begin failures++; $display("FAIL reset_pulse_b got %b expected 0", pulse_b); end
    checks++; if (moving_b !== 1'b0) begin failures++; $display("FAIL reset_moving_b got %b expected 0", moving_b); end
    checks++; if (dropped_b !== 1'b0) begin failures++; $display("FAIL reset_dropped_b got %b expected 0", dropped_b); end
    rst = 1'b0;
    repeat (5) tick();
  endtask

  task automatic test_nominal();
    int rises, highs, r0, r1, still;
    logic prev, mv4;
    rises = 0; highs = 0; r0 = -1; r1 = -1; still = 0; prev = 1'b0; mv4 = 1'b1;
    en = 1'b1;
    for (int n = 0; n < 80; n++) begin
      hall_a = ((n % 20) < 10);
      tick();
      if (pulse_a) highs++;
      if (pulse_a && !prev) begin
        rises++;
        if (r0 < 0) r0 = n; else if (r1 < 0) r1 = n;
      end
      prev = pulse_a;
      if (n == 4) mv4 = moving_a;
      if (n >= 5 && !moving_a) still++;
    end
    checks++; if (rises !== 2) begin failures++; $display("FAIL nominal_pulse_count got %0d expected 2", rises); end
    checks++; if (r0 !== 26) begin failures++; $display("FAIL nominal_first_rise got %0d expected 26", r0); end
    checks++; if (r1 !== 66) begin failures++; $display("FAIL nominal_second_rise got %0d expected 66", r1); end
    checks++; if (highs !== 4) begin failures++; $display("FAIL nominal_high_cycles got %0d expected 4", highs); end
    checks++; if (mv4 !== 1'b0) begin failures++; $display("FAIL nominal_moving_early got %b expected 0", mv4); end
    checks++; if (still !== 0) begin failures++; $display("FAIL nominal_moving_low_cycles got %0d expected 0", still); end
    checks++; if (dropped_a !== 1'b0) begin failures++; $display("FAIL nominal_dropped got %b expected 0", dropped_a); end
  endtask

  task automatic test_glitch();
    int highs, mv;
    highs = 0; mv = 0;
    hall_a = 1'b0;
    repeat (60) tick();
    checks++; if (moving_a !== 1'b0) begin failures++; $display("FAIL glitch_pre_moving got %b expected 0", moving_a); end
    for (int n = 0; n < 48; n++) begin
      hall_a = ((n % 12) < 2);
      tick();
      if (pulse_a) highs++;
      if (moving_a) mv++;
    end
    checks++; if (highs !== 0) begin failures++; $display("FAIL glitch_pulse_cycles got %0d expected 0", highs); end
    checks++; if (mv !== 0) begin failures++; $display("FAIL glitch_moving_cycles got %0d expected 0", mv); end
    hall_a = 1'b0;
    repeat (5) tick();
  endtask

  task automatic test_en_drop();
    int rises, highs, r0, highs2;
    logic prev;
    rises = 0; highs = 0; r0 = -1; highs2 = 0; prev = 1'b0;
    for (int n = 0; n < 80; n++) begin
      hall_a = ((n % 20) < 10);
      en = (n < 27);
      tick();
      if (pulse_a) highs++;
      if (pulse_a && !prev) begin rises++; if (r0 < 0) r0 = n; end
      prev = pulse_a;
    end
    checks++; if (rises !== 1) begin failures++; $display("FAIL en_drop_pulse_count got %0d expected 1", rises); end
    checks++; if (r0 !== 26) begin failures++; $display("FAIL en_drop_rise got %0d expected 26", r0); end
    checks++; if (highs !== 2) begin failures++; $display("FAIL en_drop_high_cycles got %0d expected 2", highs); end
    // One edge counted, en pulsed low, one more edge: a cleared sub count yields no pulse.
    for (int n = 0; n < 80; n++) begin
      hall_a = (n < 10) || (n >= 40 && n < 50);
      en = (n < 20) || (n >= 30);
      tick();
      if (pulse_a) highs2++;
    end
    checks++; if (highs2 !== 0) begin failures++; $display("FAIL en_drop_sub_clear got %0d expected 0", highs2); end
    en = 1'b0;
    repeat (3) tick();
    en = 1'b1;
  endtask

  task automatic test_stall_and_reset();
    logic m [0:59];
    logic p [0:29];
    int highs, late;
    highs = 0; late = 0;
    en = 1'b1; hall_a = 1'b0;
    repeat (60) tick();
    checks++; if (moving_a !== 1'b0) begin failures++; $display("FAIL stall_pre_moving got %b expected 0", moving_a); end
    for (int n = 0; n < 60; n++) begin
      hall_a = (n < 10);
      tick();
      m[n] = moving_a;
      if (pulse_a) highs++;
    end
    checks++; if (m[4] !== 1'b0) begin failures++; $display("FAIL stall_moving_at4 got %b expected 0", m[4]); end
    checks++; if (m[5] !== 1'b1) begin failures++; $display("FAIL stall_moving_at5 got %b expected 1", m[5]); end
    checks++; if (m[54] !== 1'b1) begin failures++; $display("FAIL stall_moving_at54 got %b expected 1", m[54]); end
    checks++; if (m[55] !== 1'b0) begin failures++; $display("FAIL stall_moving_at55 got %b expected 0", m[55]); end
    checks++; if (highs !== 0) begin failures++; $display("FAIL stall_pulse_cycles got %0d expected 0", highs); end
    for (int n = 0; n < 30; n++) begin
      hall_a = (n < 10);
      rst = (n == 7);
      tick();
      p[n] = pulse_a;
      if (n >= 7 && pulse_a) late++;
    end
    rst = 1'b0;
    checks++; if (p[6] !== 1'b1) begin failures++; $display("FAIL rst_pulse_before got %b expected 1", p[6]); end
    checks++; if (p[7] !== 1'b0) begin failures++; $display("FAIL rst_pulse_after got %b expected 0", p[7]); end
    checks++; if (late !== 0) begin failures++; $display("FAIL rst_late_pulse_cycles got %0d expected 0", late); end
    hall_a = 1'b0;
    repeat (5) tick();
  endtask

  task automatic test_back_to_back();
    int rise_at [0:15];
    int rises, highs, badpitch;
    logic prev;
    rises = 0; highs = 0; badpitch = 0; prev = 1'b0;
    for (int i = 0; i < 16; i++) rise_at[i] = -1;
    for (int n = 0; n < 60; n++) begin
      hall_b = (n < 20) && ((n % 4) < 2);
      tick();
      if (pulse_b) highs++;
      if (pulse_b && !prev) begin
        if (rises < 16) rise_at[rises] = n;
        rises++;
      end
      prev = pulse_b;
    end
    for (int i = 1; i < 5; i++) if (rise_at[i] - rise_at[i-1] != 8) badpitch++;
    checks++; if (rises !== 5) begin failures++; $display("FAIL b2b_pulse_count got %0d expected 5", rises); end
    checks++; if (rise_at[0] !== 4) begin failures++; $display("FAIL b2b_first_rise got %0d expected 4", rise_at[0]); end
    checks++; if (badpitch !== 0) begin failures++; $display("FAIL b2b_pitch_errors got %0d expected 0", badpitch); end
    checks++; if (highs !== 20) begin failures++; $display("FAIL b2b_high_cycles got %0d expected 20", highs); end
    checks++; if (dropped_b !== 1'b0) begin failures++; $display("FAIL b2b_dropped got %b expected 0", dropped_b); end
  endtask

  task automatic test_saturate();
    int rise_at [0:15];
    logic d [0:99];
    int rises, badpitch;
    logic prev;
    rises = 0; badpitch = 0; prev = 1'b0;
    for (int i = 0; i < 16; i++) rise_at[i] = -1;
    for (int n = 0; n < 100; n++) begin
      hall_b = (n < 56) && ((n % 4) < 2);
      tick();
      d[n] = dropped_b;
      if (pulse_b && !prev) begin
        if (rises < 16) rise_at[rises] = n;
        rises++;
      end
      prev = pulse_b;
    end
    for (int i = 1; i < 10; i++) if (rise_at[i] - rise_at[i-1] != 8) badpitch++;
    checks++; if (rises !== 10) begin failures++; $display("FAIL sat_pulse_count got %0d expected 10", rises); end
    checks++; if (rise_at[9] !== 76) begin failures++; $display("FAIL sat_last_rise got %0d expected 76", rise_at[9]); end
    checks++; if (badpitch !== 0) begin failures++; $display("FAIL sat_pitch_errors got %0d expected 0", badpitch); end
    checks++; if (d[26] !== 1'b0) begin failures++; $display("FAIL sat_dropped_at26 got %b expected 0", d[26]); end
    checks++; if (d[27] !== 1'b1) begin failures++; $display("FAIL sat_dropped_at27 got %b expected 1", d[27]); end
    checks++; if (dropped_b !== 1'b1) begin failures++; $display("FAIL sat_dropped_end got %b expected 1", dropped_b); end
  endtask

  task automatic test_pend_clear();
    logic d [0:79];
    int rises, highs;
    logic prev;
    rises = 0; highs = 0; prev = 1'b0;
    for (int n = 0; n < 80; n++) begin
      hall_b = (n < 24) && ((n % 4) < 2);
      en = !(n >= 14 && n < 60);
      tick();
      d[n] = dropped_b;
      if (pulse_b) highs++;
      if (pulse_b && !prev) rises++;
      prev = pulse_b;
    end
    en = 1'b1;
    checks++; if (rises !== 2) begin failures++; $display("FAIL pend_clear_pulse_count got %0d expected 2", rises); end
    checks++; if (highs !== 8) begin failures++; $display("FAIL pend_clear_high_cycles got %0d expected 8", highs); end
    checks++; if (d[13] !== 1'b1) begin failures++; $display("FAIL pend_clear_dropped_at13 got %b expected 1", d[13]); end
    checks++; if (d[14] !== 1'b0) begin failures++; $display("FAIL pend_clear_dropped_at14 got %b expected 0", d[14]); end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; en = 1'b0; hall_a = 1'b0; hall_b = 1'b0;
    test_reset();
    test_nominal();
    test_glitch();
    test_en_drop();
    test_stall_and_reset();
    test_back_to_back();
    test_saturate();
    test_pend_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
